// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter: CPU (M stage) has fixed priority, host is forced in after MAX_WAIT contended cycles.
// Optional perf counters (perf_stall_cnt, perf_host_cnt) are built when DMEM_ARB_PERF_EN is defined.
module dmem_port_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4,
    parameter int WAIT_W     = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [DATA_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_stall,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [DATA_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0] mem_wd,
`ifdef DMEM_ARB_PERF_EN
    output logic [15:0]           perf_stall_cnt,
    output logic [15:0]           perf_host_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] mem_rd
);

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_HOST = 2'd1,
        S_ACK  = 2'd2
    } state_e;

    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    state_e                  state_q, state_d;
    logic [WAIT_W-1:0]       wait_q, wait_d;
    logic                    ack_q, ack_d;
    logic [DATA_WIDTH-1:0]   hrdata_q, hrdata_d;
    logic                    host_sel;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_CPU;
            wait_q   <= '0;
            ack_q    <= 1'b0;
            hrdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            ack_q    <= ack_d;
            hrdata_q <= hrdata_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        ack_d    = 1'b0;
        hrdata_d = hrdata_q;
        unique case (state_q)
            S_CPU: begin
                if (host_req && cpu_req && (wait_q != WAIT_MAX))
                    wait_d = wait_q + 1'b1;
                if (host_req && (!cpu_req || (wait_q == WAIT_MAX)))
                    state_d = S_HOST;
            end
            S_HOST: begin
                // Combinational memory returns old data on a write, so report what was written.
                hrdata_d = host_we ? host_wdata : mem_rd;
                ack_d    = 1'b1;
                wait_d   = '0;
                state_d  = S_ACK;
            end
            S_ACK: begin
                state_d = S_CPU;
            end
            default: begin
                state_d = S_CPU;
                wait_d  = '0;
            end
        endcase
    end

    // Output logic
    always_comb begin
        host_sel  = (state_q == S_HOST);
        cpu_stall = host_sel & cpu_req;
        if (host_sel) begin
            mem_we = host_we;
            mem_a  = host_addr;
            mem_wd = host_wdata;
        end else begin
            mem_we = cpu_req & cpu_we;
            mem_a  = cpu_addr;
            mem_wd = cpu_wdata;
        end
        // Write enable is gated directly by the async reset so an aborted access cannot land.
        if (!reset)
            mem_we = 1'b0;
    end

    assign cpu_rdata  = mem_rd;
    assign host_ack   = ack_q;
    assign host_rdata = hrdata_q;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] perf_stall_q;
    logic [15:0] perf_host_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_q <= '0;
            perf_host_q  <= '0;
        end else begin
            if (cpu_stall && (perf_stall_q != 16'hFFFF))
                perf_stall_q <= perf_stall_q + 16'd1;
            if (ack_q && (perf_host_q != 16'hFFFF))
                perf_host_q <= perf_host_q + 16'd1;
        end
    end

    assign perf_stall_cnt = perf_stall_q;
    assign perf_host_cnt  = perf_host_q;
`endif

endmodule
